// File: rtl/alu_arbiter_if.sv
// Bus between the two requesters, the arbiter and the shared ALU.
interface alu_arbiter_if;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b,
           rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_result, rsp_zero, alu_op, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b,
           rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_result, rsp_zero, alu_op, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency ALU;
// one operation in flight, result held until the owner consumes it.
module alu_arbiter #(
  parameter int ALU_LAT = 2
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  localparam int CW = $clog2(ALU_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e        state_q;
  logic          last_grant_q, gnt_q, zero_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q, res_q;
  logic          sel, idle, accept, rsp_done;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  assign sel      = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign idle     = (state_q == IDLE) && !reset;
  assign bus.req0_ready = idle && bus.req0_valid && !sel;
  assign bus.req1_ready = idle && bus.req1_valid && sel;
  assign accept   = bus.req0_ready || bus.req1_ready;
  assign rsp_done = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q         <= sel ? bus.req1_op : bus.req0_op;
          a_q          <= sel ? bus.req1_a  : bus.req0_a;
          b_q          <= sel ? bus.req1_b  : bus.req0_b;
          gnt_q        <= sel;
          last_grant_q <= sel;
          cnt_q        <= '0;
          state_q      <= EXEC;
        end
        EXEC: begin
          cnt_q <= cnt_q + CW'(1);
          // cnt reaches ALU_LAT in cycle T+ALU_LAT+1, when the ALU output is valid.
          if (cnt_q == CW'(ALU_LAT)) begin
            res_q   <= bus.alu_result;
            zero_q  <= bus.alu_zero;
            state_q <= RESP;
          end
        end
        RESP: if (rsp_done) begin
          op_q    <= '0;
          a_q     <= '0;
          b_q     <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign bus.rsp0_valid = !reset && (state_q == RESP) && !gnt_q;
  assign bus.rsp1_valid = !reset && (state_q == RESP) && gnt_q;
  assign bus.busy       = !reset && (state_q != IDLE);
  assign bus.alu_op     = reset ? 4'd0  : op_q;
  assign bus.alu_a      = reset ? 32'd0 : a_q;
  assign bus.alu_b      = reset ? 32'd0 : b_q;
  assign bus.rsp_result = reset ? 32'd0 : res_q;
  assign bus.rsp_zero   = !reset && zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus hand-written sequences
// for arbitration, back-pressure and reset corner cases.
module tb_alu_arbiter;
  localparam int ALU_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if u_if();
  alu_arbiter #(.ALU_LAT(ALU_LAT)) dut (.clk(clk), .reset(reset), .bus(u_if));

  // Shared ALU: combinational function followed by ALU_LAT register stages.
  function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b0010: r = a - b;
      4'b1010: r = {31'd0, ($signed(a) < $signed(b))};
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  logic [32:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(u_if.alu_op, u_if.alu_a, u_if.alu_b);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign u_if.alu_result = alu_pipe[ALU_LAT-1][31:0];
  assign u_if.alu_zero   = alu_pipe[ALU_LAT-1][32];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          id;
    logic [3:0]  op;
    logic [31:0] a, b, res;
    bit          z;
  } vec_t;
  vec_t vecs [11];

  task automatic clear_inputs();
    u_if.req0_valid = 0; u_if.req1_valid = 0;
    u_if.req0_op = 0; u_if.req0_a = 0; u_if.req0_b = 0;
    u_if.req1_op = 0; u_if.req1_a = 0; u_if.req1_b = 0;
    u_if.rsp0_ready = 1; u_if.rsp1_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    clear_inputs();
    @(negedge clk);
    reset = 0;
  endtask

  // Entered at a negedge; returns at the negedge of the first EXEC cycle.
  task automatic issue(input bit id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int t_acc);
    bit ok;
    ok = 0;
    t_acc = -1;
    if (id) begin
      u_if.req1_valid = 1; u_if.req1_op = op; u_if.req1_a = a; u_if.req1_b = b;
    end else begin
      u_if.req0_valid = 1; u_if.req0_op = op; u_if.req0_a = a; u_if.req0_b = b;
    end
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      if (id ? u_if.req1_ready : u_if.req0_ready) begin
        ok = 1;
        t_acc = cyc;
      end
      @(negedge clk);
    end
    if (id) u_if.req1_valid = 0; else u_if.req0_valid = 0;
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  // Returns just after the negedge of the first response cycle.
  task automatic wait_rsp(input bit id, output int t_rsp);
    bit ok;
    ok = 0;
    t_rsp = -1;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      if (id ? u_if.rsp1_valid : u_if.rsp0_valid) begin
        ok = 1;
        t_rsp = cyc;
      end else begin
        @(negedge clk);
      end
    end
    chk("rsp_seen", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int t_acc, t_rsp, nrsp, seen;
    int g[$];

    vecs[0]  = '{0, 4'b0000, 32'd5,        32'd7,        32'd12,       0};
    vecs[1]  = '{0, 4'b0010, 32'd3,        32'd3,        32'd0,        1};
    vecs[2]  = '{1, 4'b1010, 32'd2,        32'd9,        32'd1,        0};
    vecs[3]  = '{1, 4'b1010, 32'hFFFFFFFF, 32'd1,        32'd1,        0};
    vecs[4]  = '{0, 4'b1010, 32'd1,        32'hFFFFFFFF, 32'd0,        1};
    vecs[5]  = '{1, 4'b0100, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0};
    vecs[6]  = '{0, 4'b0101, 32'h000000F0, 32'h0000000F, 32'h000000FF, 0};
    vecs[7]  = '{1, 4'b0110, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0};
    vecs[8]  = '{0, 4'b0111, 32'd0,        32'd0,        32'hFFFFFFFF, 0};
    vecs[9]  = '{1, 4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,        1};
    vecs[10] = '{1, 4'b0010, 32'd5,        32'd7,        32'hFFFFFFFE, 0};

    // Reset: outputs low even with a request pending.
    reset = 1;
    clear_inputs();
    u_if.req0_valid = 1;
    @(negedge clk);
    #1;
    chk("rst_ready0", {31'd0, u_if.req0_ready}, 32'd0);
    chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("rst_alu_op", {28'd0, u_if.alu_op}, 32'd0);
    chk("rst_result", u_if.rsp_result, 32'd0);
    @(negedge clk);
    reset = 0;
    u_if.req0_valid = 0;
    #1;
    chk("post_rst_busy", {31'd0, u_if.busy}, 32'd0);
    @(negedge clk);

    // Table vectors; valid is dropped one cycle after acceptance each time.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, t_acc);
      wait_rsp(vecs[i].id, t_rsp);
      chk($sformatf("v%0d_latency", i), t_rsp - t_acc, ALU_LAT + 2);
      chk($sformatf("v%0d_result", i), u_if.rsp_result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), {31'd0, u_if.rsp_zero}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_other_vld", i),
          {31'd0, (vecs[i].id ? u_if.rsp0_valid : u_if.rsp1_valid)}, 32'd0);
      chk($sformatf("v%0d_busy", i), {31'd0, u_if.busy}, 32'd1);
      @(negedge clk);
    end

    // Unlisted opcode is forwarded; ALU bus returns to zero in IDLE.
    issue(0, 4'b1111, 32'd1, 32'd1, t_acc);
    #1;
    chk("ill_alu_op", {28'd0, u_if.alu_op}, 32'hF);
    chk("ill_alu_a", u_if.alu_a, 32'd1);
    wait_rsp(0, t_rsp);
    chk("ill_latency", t_rsp - t_acc, ALU_LAT + 2);
    chk("ill_result", u_if.rsp_result, 32'd0);
    chk("ill_zero", {31'd0, u_if.rsp_zero}, 32'd1);
    @(negedge clk);
    #1;
    chk("idle_alu_op", {28'd0, u_if.alu_op}, 32'd0);
    chk("idle_alu_a", u_if.alu_a, 32'd0);

    // Round robin with both requesters continuously valid.
    do_reset();
    u_if.req0_op = 4'b0010; u_if.req0_a = 32'd3;    u_if.req0_b = 32'd3;
    u_if.req1_op = 4'b0101; u_if.req1_a = 32'hF0;   u_if.req1_b = 32'h0F;
    u_if.req0_valid = 1; u_if.req1_valid = 1;
    nrsp = 0;
    for (int i = 0; i < 200 && nrsp < 4; i++) begin
      #1;
      if (u_if.req0_ready) g.push_back(0);
      if (u_if.req1_ready) g.push_back(1);
      if (u_if.rsp0_valid) begin
        chk("rr_res0", u_if.rsp_result, 32'd0);
        chk("rr_zero0", {31'd0, u_if.rsp_zero}, 32'd1);
        nrsp++;
      end
      if (u_if.rsp1_valid) begin
        chk("rr_res1", u_if.rsp_result, 32'hFF);
        chk("rr_zero1", {31'd0, u_if.rsp_zero}, 32'd0);
        nrsp++;
      end
      @(negedge clk);
    end
    u_if.req0_valid = 0; u_if.req1_valid = 0;
    chk("rr_rsp_count", nrsp, 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), (i < g.size()) ? g[i] : 9, i % 2);

    // Back-pressure on requester 1 while requester 0 waits.
    do_reset();
    u_if.rsp1_ready = 0;
    issue(1, 4'b1010, 32'd2, 32'd9, t_acc);
    u_if.req0_op = 4'b0000; u_if.req0_a = 32'd1; u_if.req0_b = 32'd1;
    u_if.req0_valid = 1;
    wait_rsp(1, t_rsp);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, u_if.rsp1_valid}, 32'd1);
      chk("bp_result", u_if.rsp_result, 32'd1);
      chk("bp_busy", {31'd0, u_if.busy}, 32'd1);
      chk("bp_ready0", {31'd0, u_if.req0_ready}, 32'd0);
      @(negedge clk);
      #1;
    end
    u_if.rsp1_ready = 1;
    #1;
    chk("bp_release_ready0", {31'd0, u_if.req0_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("bp_next_ready0", {31'd0, u_if.req0_ready}, 32'd1);
    chk("bp_next_vld1", {31'd0, u_if.rsp1_valid}, 32'd0);
    @(negedge clk);
    u_if.req0_valid = 0;
    wait_rsp(0, t_rsp);
    chk("bp_req0_result", u_if.rsp_result, 32'd2);
    @(negedge clk);

    // Reset in the second EXEC cycle abandons the op and restores tie priority.
    issue(0, 4'b0111, 32'd0, 32'd0, t_acc);
    @(negedge clk);
    reset = 1;
    #1;
    chk("mid_rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("mid_rst_alu_op", {28'd0, u_if.alu_op}, 32'd0);
    chk("mid_rst_vld0", {31'd0, u_if.rsp0_valid}, 32'd0);
    @(negedge clk);
    reset = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (u_if.rsp0_valid || u_if.rsp1_valid) seen++;
      @(negedge clk);
    end
    chk("mid_rst_no_rsp", seen, 32'd0);
    chk("mid_rst_idle", {31'd0, u_if.busy}, 32'd0);
    u_if.req0_op = 4'b0000; u_if.req0_a = 32'd4; u_if.req0_b = 32'd4;
    u_if.req0_valid = 1; u_if.req1_valid = 1;
    #1;
    chk("tie_ready0", {31'd0, u_if.req0_ready}, 32'd1);
    chk("tie_ready1", {31'd0, u_if.req1_ready}, 32'd0);
    @(negedge clk);
    u_if.req0_valid = 0; u_if.req1_valid = 0;
    wait_rsp(0, t_rsp);
    chk("tie_result", u_if.rsp_result, 32'd8);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter ALU_LAT, default 2, the number of clk edges from the edge that first presents alu_op/alu_a/alu_b to the edge after which alu_result/alu_zero are valid.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_op, req1_op  input  4 each  ALU opcode (0000 add, 0010 sub, 1010 slt, 0100 and, 0101 or, 0110 xor, 0111 nor).
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-007 req0_ready, req1_ready  output  1 each  grant/accept strobe for requester N.
REQ-008 rsp0_valid, rsp1_valid  output  1 each  result available for requester N.
REQ-009 rsp0_ready, rsp1_ready  input  1 each  requester N consumes its result.
REQ-010 rsp_result  output  32  captured ALU result, shared by both requesters.
REQ-011 rsp_zero  output  1  captured ALU zero flag.
REQ-012 alu_op  output  4; alu_a, alu_b  output  32 each  registered drive to the shared ALU.
REQ-013 alu_result  input  32; alu_zero  input  1  shared ALU outputs.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC, RESP; only one operation SHALL be outstanding at any time.
REQ-016 In IDLE, reqN_ready SHALL be high combinationally for the granted requester only; the transfer occurs in the cycle where reqN_valid and reqN_ready are both high.
REQ-017 Arbitration SHALL be round-robin: a sole valid requester wins; when both are valid, the requester not granted last wins; last_grant SHALL flip only on an accepted transfer.
REQ-018 On acceptance, reqN_op/a/b SHALL be registered onto alu_op/alu_a/alu_b, the grant index stored, cnt cleared, and the FSM SHALL move to EXEC.
REQ-019 In EXEC, alu_op/alu_a/alu_b SHALL hold stable and cnt SHALL increment each cycle; both reqN_ready SHALL be low.
REQ-020 With acceptance in cycle T, alu_result and alu_zero SHALL be sampled into rsp_result/rsp_zero at the end of cycle T+ALU_LAT+1, and the FSM SHALL enter RESP.
REQ-021 In RESP, rspN_valid SHALL be high for the stored grant only, with rsp_result/rsp_zero held stable until rspN_ready is sampled high.
REQ-022 On rspN_valid and rspN_ready both high, the FSM SHALL return to IDLE; a new request SHALL not be accepted in that same cycle, so minimum throughput is one op per ALU_LAT+3 cycles.
REQ-023 In IDLE, alu_op/alu_a/alu_b SHALL be driven to zero.
REQ-024 Opcodes outside the listed set SHALL be forwarded unchanged; the result is whatever the ALU returns (zero for the shared ALU).
REQ-025 reqN_valid deasserting in EXEC or RESP SHALL have no effect; the accepted operation completes.
REQ-026 rspN_ready asserted while rspN_valid is low SHALL be ignored.

Reset
REQ-027 When reset is high at a rising edge, the FSM SHALL go to IDLE, last_grant SHALL be set to 1 (requester 0 wins the first tie), and cnt, alu_op, alu_a, alu_b, rsp_result, and rsp_zero SHALL be cleared.
REQ-028 While reset is high, all outputs SHALL be low: ready, rsp valid, busy, alu_op/a/b, rsp_result, rsp_zero.
REQ-029 Reset mid-EXEC or mid-RESP SHALL abandon the operation; no rspN_valid SHALL be raised for it afterwards.

Verification
REQ-030 Stimulus: after reset, req0 add A=5 B=7 with rsp0_ready high. Required response: req0_ready in acceptance cycle T; rsp0_valid in T+4 (ALU_LAT=2); rsp_result=12; rsp_zero=0.
REQ-031 Stimulus: both requesters valid continuously, req0 sub 3-3, req1 or 0xF0|0x0F. Required response: grants alternate 0,1,0,1; req0 results rsp_result=0 with rsp_zero=1; req1 results 0xFF.
REQ-032 Stimulus: req1 slt A=2 B=9, rsp1_ready held low for 5 cycles. Required response: rsp1_valid stays high, rsp_result=1 stable, busy=1, req0 not accepted until the cycle after rsp1_ready is sampled high.
REQ-033 Stimulus: reset asserted in the second EXEC cycle of req0 nor A=0 B=0. Required response: no rsp0_valid afterwards; state IDLE; next tie grants requester 0.
REQ-034 Stimulus: req0 opcode 4'b1111 with A=1 B=1. Required response: alu_op=1111 in EXEC; rsp_result=0; rsp_zero=1.
REQ-035 Stimulus: req0_valid dropped one cycle after acceptance. Required response: the operation completes; rsp0_valid asserts at T+4.
